// File: rtl/alu_md_if.sv
// Handshake and data bundle between the execute-stage issue logic and alu_md.
interface alu_md_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_md.sv
// MIPS-style ALU with iterative multiply/divide and HI/LO registers.
//
// state | meaning
// IDLE  | ready; simple ops complete in one cycle, mul/div ops are latched
// MUL   | radix-2 shift-add, one multiplier bit per cycle
// DIV   | restoring division, one quotient bit per cycle
// FIX   | sign correction, HI/LO/result write, out_valid pulse
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset_n,
  alu_md_if.slave bus
);
  localparam int SH = $clog2(WIDTH);
  localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

  localparam logic [4:0] OP_SLL   = 5'd0;
  localparam logic [4:0] OP_SRL   = 5'd1;
  localparam logic [4:0] OP_SRA   = 5'd2;
  localparam logic [4:0] OP_ADDU  = 5'd3;
  localparam logic [4:0] OP_SUBU  = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_NOR   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MTLO  = 5'd23;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [SH-1:0]    count;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_lat;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             out_valid_r;

  logic             accept;
  logic             op_mul;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [SH-1:0]    shamt;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  assign accept    = bus.in_valid && (state == S_IDLE);
  assign op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign mag_a     = (op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b     = (op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign shamt     = bus.b[SH-1:0];

  // Adder for one shift-add step: add the multiplicand when the low multiplier bit is set.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  // Trial subtraction of the divisor from the partial remainder with the next dividend bit.
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};

  assign prod_mag  = {acc_hi, acc_lo};
  assign prod_fix  = neg_q ? -prod_mag : prod_mag;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;

  // Single-cycle ALU and HI/LO move results.
  always_comb begin
    simple_res = '0;
    case (bus.op)
      OP_SLL:  simple_res = bus.a << shamt;
      OP_SRL:  simple_res = bus.a >> shamt;
      OP_SRA:  simple_res = $signed(bus.a) >>> shamt;
      OP_ADDU: simple_res = bus.a + bus.b;
      OP_SUBU: simple_res = bus.a - bus.b;
      OP_AND:  simple_res = bus.a & bus.b;
      OP_OR:   simple_res = bus.a | bus.b;
      OP_XOR:  simple_res = bus.a ^ bus.b;
      OP_NOR:  simple_res = ~(bus.a | bus.b);
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_LUI:  simple_res = bus.b << (WIDTH / 2);
      OP_MFHI: simple_res = hi;
      OP_MFLO: simple_res = lo;
      OP_MTHI: simple_res = bus.a;
      OP_MTLO: simple_res = bus.a;
      default: simple_res = '0;
    endcase
  end

  // Final HI/LO after sign correction; divide-by-zero bypasses the iteration result.
  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_lo = '1;
        fix_hi = a_lat;
      end else begin
        fix_lo = neg_q ? -acc_lo : acc_lo;
        fix_hi = neg_r ? -acc_hi : acc_hi;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept && op_mul) begin
          state_nx = S_MUL;
        end else if (accept && op_div) begin
          state_nx = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (count == CNT_LAST) begin
          state_nx = S_FIX;
        end
      end
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath: operand latch, iteration registers, HI/LO and registered result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      a_lat       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      result_r    <= '0;
      zero_r      <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_mul || op_div) begin
              count  <= '0;
              acc_hi <= '0;
              acc_lo <= op_mul ? mag_b : mag_a;
              opnd   <= op_mul ? mag_a : mag_b;
              a_lat  <= bus.a;
              is_div <= op_div;
              neg_q  <= op_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_r  <= op_signed && bus.a[WIDTH-1];
              b_zero <= (bus.b == '0);
            end else begin
              result_r    <= simple_res;
              zero_r      <= (simple_res == '0);
              out_valid_r <= 1'b1;
              if (bus.op == OP_MTHI) begin
                hi <= bus.a;
              end
              if (bus.op == OP_MTLO) begin
                lo <= bus.a;
              end
            end
          end
        end
        S_MUL: begin
          count  <= count + 1'b1;
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        S_DIV: begin
          count <= count + 1'b1;
          if (!div_trial[WIDTH]) begin
            acc_hi <= div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          result_r    <= fix_lo;
          zero_r      <= (fix_lo == '0);
          out_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised, handshaked MIPS-style ALU with an iterative multiply/divide unit and architectural HI/LO registers. It sits in the execute stage of the MIPS150 datapath. It covers the full single-cycle ALU op set with corrected signed/unsigned semantics, and adds MULT/MULTU/DIV/DIVU plus the MFHI/MFLO/MTHI/MTLO moves. The registered result is returned with a valid pulse, and issue stalls while a multi-cycle operation runs.

## Interface
- WIDTH, 32: datapath width; power of two, 8..64. SH = log2(WIDTH).
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation present on op/a/b.
- in_ready  out  1  block can accept; an op is accepted on an edge where in_valid && in_ready.
- op  in  5  operation select (encoding below).
- a, b  in  WIDTH  operands.
- out_valid  out  1  one-cycle pulse; result holds the value for the accepted op.
- result  out  WIDTH  registered result; holds its value between pulses.
- zero  out  1  result == 0, registered alongside result.
- busy  out  1  a multiply or divide is in progress (equal to !in_ready).

## Operation
- Encoding: 0 SLL, 1 SRL, 2 SRA, 3 ADDU, 4 SUBU, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT, 10 SLTU, 11 LUI, 16 MULT, 17 MULTU, 18 DIV, 19 DIVU, 20 MFHI, 21 MFLO, 22 MTHI, 23 MTLO. Any other code: result 0, out_valid still pulses.
- Shifts: result = a shifted by b[SH-1:0]; the upper bits of b are ignored. SRA replicates a[WIDTH-1].
- ADDU/SUBU: modulo 2^WIDTH; no overflow detection.
- NOR: bitwise ~(a|b).
- SLT: signed compare of a and b, giving 1 or 0.
- SLTU: unsigned compare of a and b, giving 1 or 0.
- LUI: b << (WIDTH/2).
- MTHI/MTLO: write a into HI/LO; result = a.
- MFHI/MFLO: result = HI/LO.
- MULT/MULTU: {HI,LO} = a*b with a 2*WIDTH-bit product.
  - Signed ops work on operand magnitudes and negate in the FIX state.
  - Radix-2 shift-add, one bit per cycle.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Restoring division, one bit per cycle.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - b == 0: LO = all ones, HI = a (no exception).
  - Signed -2^(WIDTH-1) / -1: LO = -2^(WIDTH-1), HI = 0.
- MULT/DIV result output = new LO value.
- FSM states:
  - IDLE: in_ready = 1. Accepting a simple op registers the result and raises out_valid for the next cycle. Accepting a mul/div op latches operand magnitudes and sign flags, clears the counter, and moves to MUL or DIV.
  - MUL/DIV: one iteration per cycle. After WIDTH iterations, go to FIX.
  - FIX: apply sign correction, write HI/LO and result, pulse out_valid, return to IDLE.
- Every accepted op produces exactly one out_valid pulse. Nothing is accepted while busy, and in_valid is ignored then.

## Timing
- Reset (reset_n low at an edge) drives:
  - state = IDLE, counter = 0, in_ready = 1, busy = 0
  - out_valid = 0, result = 0, zero = 1, HI = LO = 0
- Reset mid-operation aborts the operation: no out_valid pulse and HI/LO cleared. Reset overrides a simultaneous accept.
- Simple ops and MF/MT ops:
  - out_valid is high in the cycle after the accept edge (latency 1).
  - Full throughput of one op per cycle.
- MUL/DIV:
  - Accept at edge t; busy from t+1.
  - Iterations on edges t+1..t+WIDTH; FIX edge at t+WIDTH+1.
  - out_valid, the new result, and the updated HI/LO are visible in the cycle after edge t+WIDTH+1, i.e. latency WIDTH+2.
  - in_ready returns high in that same cycle, so a new op can be accepted on the next edge. That op may be MFHI/MFLO and sees the updated HI/LO.
- MTHI/MTLO take effect at the accept edge. An MFHI/MFLO accepted on the following edge reads the new value.

## Test plan
- Reset: hold reset_n low for 2 edges. Required: in_ready=1, out_valid=0, result=0, zero=1. A subsequent MFHI and MFLO each return 0.
- Simple ops, WIDTH=32, back-to-back with one op per cycle. Required: out_valid on 4 consecutive cycles.
  - SLT 0xFFFFFFFF,1 -> 1
  - SLTU 0xFFFFFFFF,1 -> 0
  - SRA 0x80000000,0x24 -> 0xF8000000 (shift amount 4)
  - SUBU 5,7 -> 0xFFFFFFFE
- Multiply:
  - MULT a=0xFFFFFFFD, b=7: out_valid exactly 34 cycles after accept, result=0xFFFFFFEB; MFHI -> 0xFFFFFFFF.
  - MULTU with the same operands: LO=0xFFFFFFEB, HI=0x00000006.
- Divide:
  - DIV 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7 / 0 -> LO=0xFFFFFFFF, HI=7.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Stall: hold in_valid high with ADDU during a MULT. Required: in_ready=0 for 33 cycles and no out_valid until the MULT completes; the ADDU is accepted in the cycle out_valid pulses.
- Abort: pull reset_n low 10 cycles into a DIVU. Required: no out_valid, in_ready=1 the cycle after, MFLO -> 0.
